// File: rtl/slave_port_ctrl.sv
// slave_port_ctrl
// Per-slave transaction controller placed after that slave's arbiter in the
// 2-master crossbar. It captures the granted master's request, runs one
// req/ack handshake on the slave bus, and returns ack/rdata/err to that master.
// It also pulses arb_ack so the arbiter can rotate to the other master.
//
// state | meaning
// ------+-------------------------------------------------------------------
// IDLE  | no transaction; waiting for a granted master with req high
// ISSUE | s_req high, captured cmd/addr/wdata on the slave bus, waiting s_ack
// DONE  | one-cycle completion: mX_ack, arb_ack, m_rdata and m_err valid

module slave_port_ctrl #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 15,
    parameter int TW      = 4
) (
    input  logic          clk,
    input  logic          reset,

    input  logic [1:0]    grant,

    input  logic          m0_req,
    input  logic          m0_cmd,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,

    input  logic          m1_req,
    input  logic          m1_cmd,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,

    output logic          m0_ack,
    output logic          m1_ack,
    output logic [DW-1:0] m_rdata,
    output logic          m_err,
    output logic          arb_ack,

    output logic          s_req,
    output logic          s_cmd,
    output logic [AW-1:0] s_addr,
    output logic [DW-1:0] s_wdata,
    input  logic          s_ack,
    input  logic [DW-1:0] s_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DONE  = 2'd2
    } state_t;

    // With TIMEOUT = 0 the comparison value is irrelevant; it is gated off.
    localparam bit            TIMEOUT_EN = (TIMEOUT != 0);
    localparam logic [TW-1:0] CNT_LAST   = (TIMEOUT == 0) ? '0 : TW'(TIMEOUT - 1);

    state_t        state;
    state_t        state_nxt;

    logic          src;
    logic          cmd;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          err;
    logic [TW-1:0] cnt;

    logic          cap_m0;
    logic          cap_m1;
    logic          ack_hit;
    logic          tmo_hit;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode. Only the granted master's req is looked at, and an
    // s_ack on the same edge as the timeout wins over the timeout.
    always_comb begin
        state_nxt = state;
        cap_m0    = 1'b0;
        cap_m1    = 1'b0;
        ack_hit   = 1'b0;
        tmo_hit   = 1'b0;
        case (state)
            IDLE: begin
                if (grant == 2'b01 && m0_req) begin
                    cap_m0    = 1'b1;
                    state_nxt = ISSUE;
                end else if (grant == 2'b10 && m1_req) begin
                    cap_m1    = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (s_ack) begin
                    ack_hit   = 1'b1;
                    state_nxt = DONE;
                end else if (TIMEOUT_EN && cnt == CNT_LAST) begin
                    tmo_hit   = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Request capture, wait counter, and completion data/err registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            src   <= 1'b0;
            cmd   <= 1'b0;
            addr  <= '0;
            wdata <= '0;
            rdata <= '0;
            err   <= 1'b0;
            cnt   <= '0;
        end else begin
            if (cap_m0) begin
                src   <= 1'b0;
                cmd   <= m0_cmd;
                addr  <= m0_addr;
                wdata <= m0_wdata;
                cnt   <= '0;
            end else if (cap_m1) begin
                src   <= 1'b1;
                cmd   <= m1_cmd;
                addr  <= m1_addr;
                wdata <= m1_wdata;
                cnt   <= '0;
            end

            if (state == ISSUE) begin
                if (ack_hit) begin
                    // Writes leave the last read data in place for m_rdata.
                    if (!cmd) begin
                        rdata <= s_rdata;
                    end
                    err <= 1'b0;
                end else begin
                    cnt <= cnt + TW'(1);
                    if (tmo_hit) begin
                        err <= 1'b1;
                    end
                end
            end
        end
    end

    // Outputs come only from registers, never straight from inputs.
    assign s_req   = (state == ISSUE);
    assign s_cmd   = cmd;
    assign s_addr  = addr;
    assign s_wdata = wdata;

    assign arb_ack = (state == DONE);
    assign m0_ack  = (state == DONE) && !src;
    assign m1_ack  = (state == DONE) &&  src;
    assign m_rdata = rdata;
    assign m_err   = (state == DONE) && err;

endmodule

// File: tb/tb_slave_port_ctrl.sv
// Bench for slave_port_ctrl with TIMEOUT=4: a table of single transactions,
// hand-written multi-cycle sequences, then random traffic against a
// transaction-age model of the port.

module tb_slave_port_ctrl;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 4;
    localparam int TW  = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    grant;
    logic          m0_req, m0_cmd, m1_req, m1_cmd;
    logic [AW-1:0] m0_addr, m1_addr;
    logic [DW-1:0] m0_wdata, m1_wdata;
    logic          m0_ack, m1_ack, m_err, arb_ack;
    logic [DW-1:0] m_rdata;
    logic          s_req, s_cmd, s_ack;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata, s_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    slave_port_ctrl #(.AW(AW), .DW(DW), .TIMEOUT(TMO), .TW(TW)) dut (
        .clk(clk), .reset(reset), .grant(grant),
        .m0_req(m0_req), .m0_cmd(m0_cmd), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m1_req(m1_req), .m1_cmd(m1_cmd), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m0_ack(m0_ack), .m1_ack(m1_ack), .m_rdata(m_rdata), .m_err(m_err),
        .arb_ack(arb_ack), .s_req(s_req), .s_cmd(s_cmd), .s_addr(s_addr),
        .s_wdata(s_wdata), .s_ack(s_ack), .s_rdata(s_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0]  grant;
        logic        cmd;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          delay;      // s_req cycle on which s_ack is given; 0 = never
        logic [31:0] srd;
        logic        exp_src;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_cycles;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [71:0] got, input logic [71:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        grant = 2'b00;
        m0_req = 1'b0; m0_cmd = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_cmd = 1'b0; m1_addr = '0; m1_wdata = '0;
        s_ack = 1'b0; s_rdata = '0;
    endtask

    task automatic run_txn(input vec_t v);
        int n;
        int guard;
        idle_inputs();
        grant = v.grant;
        if (v.grant == 2'b01) begin
            m0_req = 1'b1; m0_cmd = v.cmd; m0_addr = v.addr; m0_wdata = v.wdata;
        end else begin
            m1_req = 1'b1; m1_cmd = v.cmd; m1_addr = v.addr; m1_wdata = v.wdata;
        end
        step();
        m0_req = 1'b0;
        m1_req = 1'b0;
        n = 0;
        guard = 0;
        while (s_req === 1'b1 && guard < 20) begin
            check("txn_s_addr", 72'(s_addr), 72'(v.addr));
            check("txn_s_cmd", 72'(s_cmd), 72'(v.cmd));
            if (v.cmd) check("txn_s_wdata", 72'(s_wdata), 72'(v.wdata));
            n++;
            if (n == v.delay) begin
                s_ack = 1'b1;
                s_rdata = v.srd;
            end
            step();
            s_ack = 1'b0;
            guard++;
        end
        check("txn_sreq_cycles", 72'(n), 72'(v.exp_cycles));
        check("txn_acks", 72'({m0_ack, m1_ack, arb_ack}), 72'({!v.exp_src, v.exp_src, 1'b1}));
        check("txn_m_rdata", 72'(m_rdata), 72'(v.exp_rdata));
        check("txn_m_err", 72'(m_err), 72'(v.exp_err));
        step();
        check("txn_after_done", 72'({m0_ack, m1_ack, arb_ack, m_err, s_req}), 72'(0));
    endtask

    // Reference model: a transaction is either absent, issued with a known
    // age in cycles, or completed and awaiting its one-cycle acknowledgement.
    int          md_age;
    bit          md_done;
    bit          md_src, md_cmd, md_err;
    logic [31:0] md_addr, md_wdata, md_rdata;

    task automatic model_edge();
        if (md_done) begin
            md_done = 1'b0;
        end else if (md_age >= 0) begin
            if (s_ack) begin
                if (!md_cmd) md_rdata = s_rdata;
                md_err = 1'b0;
                md_done = 1'b1;
                md_age = -1;
            end else if (md_age + 1 == TMO) begin
                md_err = 1'b1;
                md_done = 1'b1;
                md_age = -1;
            end else begin
                md_age++;
            end
        end else if (grant == 2'b01 && m0_req) begin
            md_src = 1'b0; md_cmd = m0_cmd; md_addr = m0_addr; md_wdata = m0_wdata; md_age = 0;
        end else if (grant == 2'b10 && m1_req) begin
            md_src = 1'b1; md_cmd = m1_cmd; md_addr = m1_addr; md_wdata = m1_wdata; md_age = 0;
        end
    endtask

    initial begin
        int          acks;
        int          last_ack_cyc;
        int          cyc;
        logic [3:0]  seq;

        // 6-entry table: reads, writes, ack at the last legal cycle, timeouts.
        vecs[0] = '{2'b01, 1'b0, 32'h10, 32'h0,  2, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0, 2};
        vecs[1] = '{2'b10, 1'b1, 32'h20, 32'h55, 1, 32'h00001234, 1'b1, 32'hDEADBEEF, 1'b0, 1};
        vecs[2] = '{2'b01, 1'b0, 32'h30, 32'h0,  4, 32'h0000A5A5, 1'b0, 32'h0000A5A5, 1'b0, 4};
        vecs[3] = '{2'b01, 1'b0, 32'h34, 32'h0,  0, 32'h0,        1'b0, 32'h0000A5A5, 1'b1, 4};
        vecs[4] = '{2'b10, 1'b0, 32'h44, 32'h0,  3, 32'h0000CAFE, 1'b1, 32'h0000CAFE, 1'b0, 3};
        vecs[5] = '{2'b01, 1'b1, 32'h48, 32'h99, 0, 32'h0,        1'b0, 32'h0000CAFE, 1'b1, 4};

        idle_inputs();
        reset = 1'b0;
        #12;
        check("reset_outputs", 72'({m0_ack, m1_ack, arb_ack, m_err, s_req, s_cmd}), 72'(0));
        check("reset_rdata", 72'(m_rdata), 72'(0));
        check("reset_s_addr", 72'(s_addr), 72'(0));
        step();
        reset = 1'b1;
        step();

        for (int i = 0; i < 6; i++) begin
            run_txn(vecs[i]);
        end

        // Ungranted / illegal grant patterns never start a transaction.
        idle_inputs();
        grant = 2'b01; m1_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("grant01_m0idle_s_req", 72'({s_req, m0_ack, m1_ack}), 72'(0));
        end
        grant = 2'b11; m0_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("grant11_s_req", 72'({s_req, m0_ack, m1_ack}), 72'(0));
        end
        grant = 2'b00;
        for (int i = 0; i < 3; i++) begin
            step();
            check("grant00_s_req", 72'({s_req, m0_ack, m1_ack}), 72'(0));
        end

        // Alternation: both masters request, grant toggles when arb_ack is seen.
        idle_inputs();
        step();
        m0_req = 1'b1; m1_req = 1'b1; grant = 2'b01; s_ack = 1'b1;
        acks = 0; last_ack_cyc = 0; seq = '0;
        for (cyc = 1; cyc <= 30 && acks < 4; cyc++) begin
            step();
            if (m0_ack || m1_ack) begin
                seq[acks] = m1_ack;
                if (acks > 0) check("alt_gap", 72'(cyc - last_ack_cyc), 72'(3));
                last_ack_cyc = cyc;
                acks++;
            end
            if (arb_ack) grant = (grant == 2'b01) ? 2'b10 : 2'b01;
        end
        check("alt_count", 72'(acks), 72'(4));
        check("alt_src_seq", 72'(seq), 72'(4'b1010));
        idle_inputs();
        step();

        // Disturbance during ISSUE must not touch the captured request.
        grant = 2'b01; m0_req = 1'b1; m0_addr = 32'h40;
        step();
        grant = 2'b10; m0_addr = 32'h99; m1_req = 1'b1; m1_addr = 32'h77;
        check("dist_s_addr0", 72'({s_req, s_addr}), 72'({1'b1, 32'h40}));
        step();
        check("dist_s_addr1", 72'({s_req, s_addr}), 72'({1'b1, 32'h40}));
        s_ack = 1'b1; s_rdata = 32'h00000777;
        step();
        idle_inputs();
        check("dist_acks", 72'({m0_ack, m1_ack, arb_ack}), 72'(3'b101));
        check("dist_rdata", 72'(m_rdata), 72'(32'h777));
        step();

        // Reset during ISSUE aborts immediately; no late ack afterwards.
        grant = 2'b01; m0_req = 1'b1; m0_addr = 32'h70;
        step();
        idle_inputs();
        check("rst_pre_s_req", 72'(s_req), 72'(1));
        #2;
        reset = 1'b0;
        #1;
        check("rst_async_s_req", 72'({s_req, m_rdata}), 72'(0));
        step();
        step();
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("rst_no_ack", 72'({m0_ack, m1_ack, arb_ack, s_req}), 72'(0));
        end

        // Random traffic, starting from a fresh reset so the model is exact.
        reset = 1'b0;
        #1;
        step();
        reset = 1'b1;
        md_age = -1; md_done = 1'b0; md_src = 1'b0; md_cmd = 1'b0; md_err = 1'b0;
        md_addr = '0; md_wdata = '0; md_rdata = '0;
        for (int i = 0; i < 1500; i++) begin
            grant    = 2'($urandom_range(0, 3));
            m0_req   = ($urandom_range(0, 3) != 0);
            m1_req   = ($urandom_range(0, 3) != 0);
            m0_cmd   = 1'($urandom_range(0, 1));
            m1_cmd   = 1'($urandom_range(0, 1));
            m0_addr  = $urandom;
            m1_addr  = $urandom;
            m0_wdata = $urandom;
            m1_wdata = $urandom;
            s_ack    = ($urandom_range(0, 3) == 0);
            s_rdata  = $urandom;
            step();
            model_edge();
            check("rnd_s_req", 72'(s_req), 72'(md_age >= 0));
            check("rnd_acks", 72'({m0_ack, m1_ack, arb_ack}),
                  72'({md_done && !md_src, md_done && md_src, md_done}));
            check("rnd_m_err", 72'(m_err), 72'(md_done && md_err));
            check("rnd_m_rdata", 72'(m_rdata), 72'(md_rdata));
            if (md_age >= 0) begin
                check("rnd_s_bus", {7'd0, s_cmd, s_addr, s_wdata}, {7'd0, md_cmd, md_addr, md_wdata});
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
